// File: rtl/fpcvt_pkg.sv
// fpcvt_pkg: shared types and helpers for the pipelined fixed-point to
// short-float converter.
//   rnd_e      : rounding mode carried alongside each sample
//   emax()     : largest encodable exponent for a given exponent width
//   params_ok(): legality check for the DW/EW/MW parameter combination
//   s1_t, s2_t : payloads of the sign/magnitude and normalise stages.
//                Fields are sized for the widest legal sample (DW_MAX), and
//                the unused upper bits stay zero.
package fpcvt_pkg;

  typedef enum logic {
    RND_NEAREST = 1'b0,  // round half up
    RND_TRUNC   = 1'b1   // drop the bits below the significand
  } rnd_e;

  localparam int DW_MAX = 32;
  // Widest unrounded exponent is DW_MAX-1-2 = 29, which needs 5 bits.
  localparam int E0W    = 5;

  function automatic int emax(input int ew);
    return (1 << ew) - 1;
  endfunction

  function automatic bit params_ok(input int dw, input int ew, input int mw);
    return (dw >= 6) && (dw <= DW_MAX) && (ew >= 1) && (ew <= 16) &&
           (mw >= 2) && (mw < dw) && ((dw - 1 - mw) <= emax(ew));
  endfunction

  typedef struct packed {
    logic              s;      // sign of the sample
    logic [DW_MAX-1:0] mag;    // |sample|, zero-extended
    logic              clamp;  // most-negative input was clamped
    rnd_e              rnd;
  } s1_t;

  typedef struct packed {
    logic              s;
    logic [E0W-1:0]    e0;     // exponent before rounding
    logic [DW_MAX-1:0] f0;     // truncated significand, zero-extended
    logic              r;      // first bit below the significand
    logic              clamp;
    rnd_e              rnd;
  } s2_t;

endpackage

// File: rtl/fpcvt_lzc.sv
// fpcvt_lzc: combinational leading-zero counter.
//   d  : W-bit input vector
//   lz : number of zeros above the most significant one (W when d == 0)
module fpcvt_lzc #(
  parameter int W = 12
) (
  input  logic [W-1:0]             d,
  output logic [$clog2(W+1)-1:0]   lz
);

  localparam int LZW = $clog2(W + 1);

  // Scanning upward lets the highest set bit overwrite every lower one.
  always_comb begin
    lz = LZW'(W);
    for (int i = 0; i < W; i++) begin
      if (d[i]) lz = LZW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fpcvt_pipe.sv
// fpcvt_pipe: three-stage pipelined converter from DW-bit two's-complement
// samples to sign / EW-bit exponent / MW-bit significand, value
// (-1)^s * f * 2^e.  A single global enable stalls every stage together.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake (in_ready depends on pipeline state only)
//   in_data, in_round   : sample and rounding mode (0 nearest, 1 truncate)
//   out_valid/out_ready : output handshake
//   out_s, out_e, out_f : sign, exponent, significand
//   out_sat             : result was clamped (most-negative input or exponent overflow)
module fpcvt_pipe
  import fpcvt_pkg::*;
#(
  parameter int DW = 12,
  parameter int EW = 3,
  parameter int MW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_round,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_s,
  output logic [EW-1:0] out_e,
  output logic [MW-1:0] out_f,
  output logic          out_sat
);

  if (!params_ok(DW, EW, MW)) begin : g_param_check
    $error("fpcvt_pipe: illegal DW/EW/MW combination");
  end

  localparam int                LZW      = $clog2(DW + 1);
  localparam logic [DW-1:0]     MOST_NEG = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]     MAX_POS  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW_MAX-1:0] MAG_KEEP = DW_MAX'({DW{1'b1}});
  localparam logic [DW_MAX-1:0] F_KEEP   = DW_MAX'({MW{1'b1}});
  localparam logic [DW-1:0]     SH_KEEP  = DW'({MW{1'b1}});

  logic en;
  logic v1, v2;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  // A full output register that is not being drained blocks every stage.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------- S1: sign / magnitude ----------------
  logic [DW-1:0] mag1;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    s1_d       = '0;
    mag1       = in_data;
    s1_d.s     = in_data[DW-1];
    s1_d.rnd   = rnd_e'(in_round);
    if (in_data == MOST_NEG) begin
      // -2^(DW-1) has no positive counterpart in DW bits.
      mag1       = MAX_POS;
      s1_d.clamp = 1'b1;
    end else if (in_data[DW-1]) begin
      mag1 = -in_data;
    end
    s1_d.mag = DW_MAX'(mag1);
  end

  // ---------------- S2: normalise ----------------
  logic [DW-1:0]  mag2;
  logic [LZW-1:0] lz;
  logic [DW-1:0]  shifted;
  int             e0;

  assign mag2 = s1_q.mag[DW-1:0];

  fpcvt_lzc #(.W(DW)) u_lzc (
    .d  (mag2),
    .lz (lz)
  );

  always_comb begin
    s2_d  = '0;
    // Shift just far enough that the leading one lands in the top
    // significand bit; small values are not shifted at all.
    e0    = DW - int'(lz) - MW;
    if (e0 < 0) e0 = 0;
    shifted    = mag2 >> e0;
    s2_d.s     = s1_q.s;
    s2_d.e0    = E0W'(e0);
    s2_d.f0    = DW_MAX'(shifted[MW-1:0]);
    s2_d.clamp = s1_q.clamp;
    s2_d.rnd   = s1_q.rnd;
    if (e0 > 0) s2_d.r = |(mag2 & (DW'(1) << (e0 - 1)));
  end

  // ---------------- S3: round and pack ----------------
  logic          round_up;
  logic [MW:0]   f1;
  logic [EW:0]   e1;
  logic [MW-1:0] f_n;
  logic [EW-1:0] e_n;
  logic          sat_n;

  always_comb begin
    round_up = (s2_q.rnd == RND_NEAREST) && s2_q.r;
    f1       = {1'b0, s2_q.f0[MW-1:0]} + {{MW{1'b0}}, round_up};
    e1       = (EW+1)'(s2_q.e0);
    f_n      = f1[MW-1:0];
    sat_n    = s2_q.clamp;
    if (f1[MW]) begin
      // Rounding carried out of the significand: renormalise.
      f_n = {1'b1, {(MW-1){1'b0}}};
      e1  = e1 + (EW+1)'(1);
    end
    e_n = e1[EW-1:0];
    if (e1 > (EW+1)'(emax(EW))) begin
      e_n   = EW'(emax(EW));
      f_n   = '1;
      sat_n = 1'b1;
    end
  end

  // ---------------- registers ----------------
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's value from before this clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_s     <= 1'b0;
      out_e     <= '0;
      out_f     <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (v2) begin
        out_s   <= s2_q.s;
        out_e   <= e_n;
        out_f   <= f_n;
        out_sat <= sat_n;
      end
    end
  end

  // NOTE: intermediate payloads carry no reset; they are only observed
  // through the valid bits, which are reset.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // Padding bits above DW/MW are constant zero; gathered here so they are
  // visibly consumed.
  logic unused_pad_bits;
  assign unused_pad_bits = ^{s1_q.mag & ~MAG_KEEP, s2_q.f0 & ~F_KEEP,
                             shifted & ~SH_KEEP};

endmodule

// File: tb/tb_fpcvt_pipe.sv
// tb_fpcvt_pipe: directed table for the default 12/3/4 converter, latency,
// backpressure and mid-flight reset sequences, plus a 16/4/6 instance
// checked against an independent reference model.
module tb_fpcvt_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, in_round;
  logic [11:0] in_data;
  logic        out_valid, out_ready, out_s, out_sat;
  logic [2:0]  out_e;
  logic [3:0]  out_f;

  logic        in_valid16, in_ready16, in_round16;
  logic [15:0] in_data16;
  logic        out_valid16, out_ready16, out_s16, out_sat16;
  logic [3:0]  out_e16;
  logic [5:0]  out_f16;

  fpcvt_pipe #(.DW(12), .EW(3), .MW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_round(in_round),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_e(out_e), .out_f(out_f), .out_sat(out_sat)
  );

  fpcvt_pipe #(.DW(16), .EW(4), .MW(6)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16), .in_round(in_round16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_s(out_s16), .out_e(out_e16), .out_f(out_f16), .out_sat(out_sat16)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Result packed as 0xSS_EE_FF_TT (sign, exponent, significand, sat).
  function automatic int pk(input int s, input int e, input int f, input int sat);
    return (s << 24) | (e << 16) | (f << 8) | sat;
  endfunction

  function automatic int got12();
    return pk(int'(out_s), int'(out_e), int'(out_f), int'(out_sat));
  endfunction

  // Reference: smallest shift that fits the significand, then round on the
  // discarded remainder, renormalise, saturate.
  function automatic int model(input int dw, input int ew, input int mw,
                               input longint v, input bit trunc);
    longint m, f, lim;
    int     e;
    bit     s, sat;
    s   = (v < 0);
    sat = 1'b0;
    m   = s ? -v : v;
    lim = (longint'(1) << (dw - 1)) - 1;
    if (m > lim) begin
      m   = lim;
      sat = 1'b1;
    end
    e = 0;
    while ((m >> e) >= (longint'(1) << mw)) e++;
    f = m >> e;
    if (!trunc && e > 0) begin
      longint rem;
      rem = m - (f << e);
      if (2 * rem >= (longint'(1) << e)) f++;
    end
    if (f == (longint'(1) << mw)) begin
      f = longint'(1) << (mw - 1);
      e++;
    end
    if (e > (1 << ew) - 1) begin
      e   = (1 << ew) - 1;
      f   = (longint'(1) << mw) - 1;
      sat = 1'b1;
    end
    return pk(int'(s), e, int'(f), int'(sat));
  endfunction

  typedef struct {
    logic [11:0] d;
    bit          trunc;
    bit          s;
    int          e;
    int          f;
    bit          sat;
  } vec_t;

  vec_t vecs[21];
  int   n_vecs = 0;

  task automatic add(input logic [11:0] d, input bit trunc, input bit s,
                     input int e, input int f, input bit sat);
    vecs[n_vecs] = '{d, trunc, s, e, f, sat};
    n_vecs++;
  endtask

  function automatic int exp_of(input vec_t v);
    return pk(int'(v.s), v.e, v.f, int'(v.sat));
  endfunction

  // One sample into an empty pipe; result must appear exactly 3 cycles later.
  task automatic run_single(input int idx);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check($sformatf("vec%0d in_ready", idx), int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = vecs[idx].d;
    in_round = vecs[idx].trunc;
    while (lat < 10) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    check($sformatf("vec%0d latency", idx), got ? lat : -1, 3);
    check($sformatf("vec%0d d=%03h", idx, vecs[idx].d), got12(), exp_of(vecs[idx]));
  endtask

  // Stream vecs[2..9], stalling the consumer for 5 cycles mid-stream.
  task automatic run_backpressure();
    int sent, recv, snap;
    bit have_snap;
    sent = 0; recv = 0; snap = 0; have_snap = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc < 10);
      #1;
      if (!out_ready) check($sformatf("bp in_ready cyc%0d", cyc), int'(in_ready), 0);
      if (out_valid) begin
        if (out_ready) begin
          if (recv < 8) check($sformatf("bp result%0d", recv), got12(), exp_of(vecs[2 + recv]));
          recv++;
          have_snap = 1'b0;
        end else if (have_snap) begin
          check($sformatf("bp hold cyc%0d", cyc), got12(), snap);
        end else begin
          snap      = got12();
          have_snap = 1'b1;
        end
      end
      if (sent < 8) begin
        in_valid = 1'b1;
        in_data  = vecs[2 + sent].d;
        in_round = vecs[2 + sent].trunc;
        if (in_ready) sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp delivered count", recv, 8);
  endtask

  // Reset with three samples in flight; only the post-reset sample emerges.
  task automatic run_reset_midflight();
    logic [11:0] pre [3];
    int seen;
    pre[0] = 12'h7FF; pre[1] = 12'h800; pre[2] = 12'h400;
    seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = pre[i];
      in_round = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("rst pre out_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rst out_valid", int'(out_valid), 0);
    check("rst out fields", got12(), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 12'h02D;
    in_round = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        seen++;
        if (seen == 1) check("rst post result", got12(), pk(0, 2, 11, 0));
      end
    end
    check("rst post count", seen, 1);
  endtask

  // 16/4/6 instance: 10k samples, random consumer stalls, both round modes.
  localparam int NSW = 10000;
  logic [15:0] sw_d [NSW];
  bit          sw_r [NSW];

  task automatic run_sweep();
    int q[$];
    int idx, nrecv, expv;
    idx = 0; nrecv = 0;
    sw_d[0] = 16'h8000; sw_r[0] = 1'b0;
    sw_d[1] = 16'h8000; sw_r[1] = 1'b1;
    sw_d[2] = 16'h7FFF; sw_r[2] = 1'b0;
    sw_d[3] = 16'h7FFF; sw_r[3] = 1'b1;
    for (int i = 4; i < NSW; i++) begin
      sw_d[i] = 16'($urandom);
      if (i % 4 == 0) sw_d[i] = sw_d[i] >> $urandom_range(0, 15);
      sw_r[i] = 1'($urandom_range(0, 1));
    end
    for (int cyc = 0; cyc < 40000; cyc++) begin
      @(negedge clk);
      out_ready16 = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid16 && out_ready16) begin
        if (q.size() == 0) begin
          check("sweep spurious output", 1, 0);
        end else begin
          expv = q.pop_front();
          check($sformatf("sweep #%0d", nrecv),
                pk(int'(out_s16), int'(out_e16), int'(out_f16), int'(out_sat16)), expv);
        end
        nrecv++;
      end
      if (idx < NSW) begin
        in_valid16 = 1'b1;
        in_data16  = sw_d[idx];
        in_round16 = sw_r[idx];
        if (in_ready16) begin
          q.push_back(model(16, 4, 6, longint'($signed(sw_d[idx])), sw_r[idx]));
          idx++;
        end
      end else begin
        in_valid16 = 1'b0;
        if (q.size() == 0) break;
      end
    end
    in_valid16  = 1'b0;
    out_ready16 = 1'b1;
    check("sweep delivered count", nrecv, NSW);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0; in_data   = '0; in_round   = 1'b0; out_ready   = 1'b1;
    in_valid16  = 1'b0; in_data16 = '0; in_round16 = 1'b0; out_ready16 = 1'b1;

    //  data     trunc s  e  f   sat
    add(12'h000, 0, 0, 0, 0,  0);
    add(12'hFFF, 0, 1, 0, 1,  0);
    add(12'h02D, 0, 0, 2, 11, 0);
    add(12'h02E, 0, 0, 2, 12, 0);
    add(12'h03E, 0, 0, 3, 8,  0);
    add(12'h7FF, 0, 0, 7, 15, 1);
    add(12'h7FF, 1, 0, 7, 15, 0);
    add(12'h800, 0, 1, 7, 15, 1);
    add(12'h800, 1, 1, 7, 15, 1);
    add(12'h02E, 1, 0, 2, 11, 0);
    add(12'h00F, 0, 0, 0, 15, 0);
    add(12'h010, 0, 0, 1, 8,  0);
    add(12'h011, 0, 0, 1, 9,  0);
    add(12'hFD3, 0, 1, 2, 11, 0);
    add(12'hFC2, 0, 1, 3, 8,  0);
    add(12'h400, 0, 0, 7, 8,  0);
    add(12'h7C0, 0, 0, 7, 15, 1);
    add(12'h7C0, 1, 0, 7, 15, 0);
    add(12'h3FF, 0, 0, 7, 8,  0);
    add(12'h001, 1, 0, 0, 1,  0);
    add(12'hFFE, 1, 1, 0, 2,  0);

    repeat (3) @(negedge clk);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out fields", got12(), 0);
    check("reset out_valid16", int'(out_valid16), 0);
    rst_n = 1'b1;

    for (int i = 0; i < n_vecs; i++) run_single(i);
    repeat (2) @(negedge clk);
    run_backpressure();
    run_reset_midflight();
    run_sweep();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpcvt_pipe.md
Name: fpcvt_pipe

Overview:
- Parametrised, pipelined two's-complement fixed-point to short-float converter; successor to the combinational 12-bit converter.
- Accepts a stream of DW-bit signed samples on a valid/ready interface.
- Emits sign, EW-bit exponent and MW-bit significand with selectable rounding and a saturation flag.
- Sits between sample producers (ADC/accumulator paths) and compact-storage or display logic.

Parameters:
- DW, 12, input data width in bits (two's complement); legal range 6..32.
- EW, 3, exponent width.
- MW, 4, significand width; elaboration error unless DW-1-MW <= 2**EW-1 and MW >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  converter can accept a sample this cycle.
- in_data  in  DW  two's-complement sample.
- in_round  in  1  rounding mode sampled with the data: 0 = round-half-up (nearest), 1 = truncate.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_s  out  1  sign.
- out_e  out  EW  exponent.
- out_f  out  MW  significand.
- out_sat  out  1  result was clamped.

Behaviour:
- Reset: asynchronous on rst_n low. All stage valid bits clear; out_valid=0, out_s=0, out_e=0, out_f=0, out_sat=0.
- in_ready is combinational from pipeline state only; it must not depend on in_valid.
- Reset asserted mid-operation discards all in-flight samples; no partial result appears after release.
- Pipeline: 3 registered stages, global stall.
  - en = !out_valid || out_ready; in_ready = en.
  - When en is 1, every stage advances and a bubble enters S1 if in_valid=0.
  - When en is 0, all stage registers, including the outputs, hold.
  - Bubbles are not collapsed while stalled.
  - Latency is exactly 3 cycles from an accepted input to out_valid when out_ready is held high. Throughput is 1 sample per cycle.
- Transfers: an input transfers when in_valid && in_ready; an output transfers when out_valid && out_ready. Output fields are stable while out_valid=1 and out_ready=0.
- S1, sign/magnitude:
  - S = in_data[DW-1]; M = |in_data| over DW bits.
  - If in_data = -2^(DW-1), then M = 2^(DW-1)-1 and the clamp flag is set.
- S2, normalise:
  - lz = leading-zero count of M over DW bits.
  - E0 = max(0, DW-lz-MW); F0 = (M >> E0)[MW-1:0].
  - R = M[E0-1] if E0>0, else 0.
- S3, round and pack:
  - In nearest mode with R=1: F1 = F0+1.
  - If F1 = 2^MW, then F = 2^(MW-1) and E = E0+1.
  - If E > 2^EW-1, then E = 2^EW-1, F = all ones, and the clamp flag is set.
  - In truncate mode, R is ignored.
  - out_sat = the OR of the clamp flags from S1 and S3.
- Zero input gives S=0, E=0, F=0, sat=0.
- Negative values produce the magnitude encoding with S=1; there is no negative zero.
- Value represented: (-1)^S × F × 2^E.

Decomposition:
- fpcvt_pkg holds:
  - the round-mode enum (RND_NEAREST=0, RND_TRUNC=1);
  - localparam helpers EMAX(EW) and a width-check function;
  - the stage payload struct typedefs (sign, magnitude, clamp, mode; then sign, E0, F0, R, clamp, mode).
- One sub-module, fpcvt_lzc: combinational leading-zero counter, parametrised on width, returning $clog2(DW+1) bits.

Test Plan:
- After reset with defaults, 0x000 -> S=0 E=0 F=0000 sat=0. 0xFFF (-1) -> S=1 E=0 F=0001 sat=0. Check both appear exactly 3 cycles after acceptance.
- Rounding, nearest mode:
  - 0x02D (45) -> E=2 F=1011.
  - 0x02E (46) -> E=2 F=1100.
  - 0x03E (62) -> significand carry gives E=3 F=1000.
- Saturation:
  - 0x7FF nearest -> S=0 E=7 F=1111 sat=1.
  - 0x7FF truncate -> E=7 F=1111 sat=0.
  - 0x800 -> S=1 E=7 F=1111 sat=1.
- Backpressure: stream 8 samples, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, outputs held stable, all 8 results delivered in order with none lost or duplicated.
- Reset while 3 samples are in flight -> out_valid=0 immediately; after release, only post-reset samples emerge.
- Parameter sweep DW=16 EW=4 MW=6 with 10k random samples against a reference model, both round modes -> bit-exact match, including the -32768 and 32767 corner values.
